// File: rtl/mux16_arbiter_if.sv
// Handshake bundle between the two 16-bit producers, the arbiter and the
// single downstream consumer. The arbiter uses the slave modport; the
// environment (producers plus consumer) uses the master modport.
interface mux16_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, sel, out_data, out_src, out_valid
    );

    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, sel, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux16_arbiter.sv
// Two-requester arbiter sharing one 16-bit 2:1 mux. The granted word is
// captured in a single output register with a valid/ready handshake, and
// per-source acceptance counters are kept for debug.
//
// Optional feature: MUX16_ARB_RR_EN
//   defined   -> round-robin tie-break using last_src (A wins the first tie)
//   undefined -> fixed priority, A always wins a tie, no last_src register
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | output register holds nothing, any granted word loads
// ST_FULL  | output register holds a word, reload only while drained

module mux16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sel_i,
    output logic [15:0] out_o
);
    // Plain 2:1 word select, 0 picks A.
    assign out_o = sel_i ? b_i : a_i;
endmodule

module mux16_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux16_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]  a_count_o,
    output logic [CNT_W-1:0]  b_count_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_src_q;
    logic [CNT_W-1:0]   a_count_q;
    logic [CNT_W-1:0]   b_count_q;

    logic [WIDTH-1:0]   out_data_d;
    logic [CNT_W-1:0]   a_count_d;
    logic [CNT_W-1:0]   b_count_d;

    logic               load_en;
    logic               gnt_vld;
    logic               gnt_b;
    logic               accept;

`ifdef MUX16_ARB_RR_EN
    // Source of the most recent acceptance; resets to B so A takes the first tie.
    logic               last_src_q;

    // Round-robin grant: a tie goes to whichever source did not win last.
    always_comb begin
        gnt_vld = bus.a_valid | bus.b_valid;
        gnt_b   = bus.b_valid & (~bus.a_valid | ~last_src_q);
    end
`else
    // Fixed-priority grant: B is only served while A is idle.
    always_comb begin
        gnt_vld = bus.a_valid | bus.b_valid;
        gnt_b   = bus.b_valid & ~bus.a_valid;
    end
`endif

    // Load window: empty register, or full register being drained this cycle.
    always_comb begin
        load_en = (state_q == ST_EMPTY) | bus.out_ready;
        accept  = load_en & gnt_vld;
    end

    // sel is the grant index; it stays 0 when nothing is granted.
    assign bus.sel     = gnt_b;
    assign bus.a_ready = load_en & gnt_vld & ~gnt_b;
    assign bus.b_ready = load_en & gnt_b;

    mux16 u_mux16 (
        .a_i   (bus.a_data),
        .b_i   (bus.b_data),
        .sel_i (gnt_b),
        .out_o (out_data_d)
    );

    // Wrapping acceptance counters, next values.
    always_comb begin
        a_count_d = a_count_q + CNT_W'(1);
        b_count_d = b_count_q + CNT_W'(1);
    end

    // Output-register FSM: load on acceptance, empty on a drain with no grant,
    // otherwise hold everything stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            a_count_q  <= '0;
            b_count_q  <= '0;
`ifdef MUX16_ARB_RR_EN
            last_src_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q    <= ST_FULL;
                        out_data_q <= out_data_d;
                        out_src_q  <= gnt_b;
`ifdef MUX16_ARB_RR_EN
                        last_src_q <= gnt_b;
`endif
                        if (gnt_b) begin
                            b_count_q <= b_count_d;
                        end else begin
                            a_count_q <= a_count_d;
                        end
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        out_data_q <= out_data_d;
                        out_src_q  <= gnt_b;
`ifdef MUX16_ARB_RR_EN
                        last_src_q <= gnt_b;
`endif
                        if (gnt_b) begin
                            b_count_q <= b_count_d;
                        end else begin
                            a_count_q <= a_count_d;
                        end
                    end else if (bus.out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign a_count_o     = a_count_q;
    assign b_count_o     = b_count_q;

    // Both sources must never be accepted on the same edge.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.a_ready && bus.b_ready));

    // A stalled output word must not change under backpressure.
    assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_src)));

endmodule

// File: tb/tb_mux16_arbiter.sv
module tb_mux16_arbiter;

`ifdef MUX16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_count;
    logic [7:0] b_count;

    always #5 clk = ~clk;

    mux16_arbiter_if #(.WIDTH(16)) bus ();

    mux16_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .a_count_o (a_count),
        .b_count_o (b_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents, counters, tie-break memory,
    // and a queue of accepted-but-not-yet-consumed words.
    bit          m_full;
    logic [15:0] m_data;
    bit          m_src;
    bit          m_last;
    logic [7:0]  m_acnt;
    logic [7:0]  m_bcnt;
    logic [16:0] exp_q[$];

    logic        c_av, c_bv, c_ordy;
    logic [15:0] c_ad, c_bd;
    bit          m_load, m_gnt, m_gsrc;
    bit          e_ar, e_br, e_sel;

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 16'h0;
        m_src  = 1'b0;
        m_last = 1'b1;
        m_acnt = 8'h0;
        m_bcnt = 8'h0;
        exp_q.delete();
    endtask

    // Apply inputs (called just after a falling edge) and predict the
    // combinational response from the arbitration rules.
    task automatic drive(input logic av, input logic [15:0] ad,
                         input logic bv, input logic [15:0] bd,
                         input logic ordy);
        c_av = av; c_ad = ad; c_bv = bv; c_bd = bd; c_ordy = ordy;
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
        m_load = !m_full || ordy;
        m_gnt  = av || bv;
        if (av && bv) m_gsrc = RR ? !m_last : 1'b0;
        else          m_gsrc = bv;
        e_sel = m_gnt ? m_gsrc : 1'b0;
        e_ar  = m_load && m_gnt && !m_gsrc;
        e_br  = m_load && m_gnt && m_gsrc;
        #1;
    endtask

    // Advance one clock edge and update the model; returns just after the next falling edge.
    task automatic tick();
        logic [15:0] word;
        @(posedge clk);
        #1;
        if (m_full && c_ordy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_load && m_gnt) begin
            word   = m_gsrc ? c_bd : c_ad;
            exp_q.push_back({m_gsrc, word});
            m_data = word;
            m_src  = m_gsrc;
            m_last = m_gsrc;
            if (m_gsrc) m_bcnt = m_bcnt + 8'd1;
            else        m_acnt = m_acnt + 8'd1;
            m_full = 1'b1;
        end else if (m_load) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        bus.a_valid = 1'b0; bus.a_data = 16'h0;
        bus.b_valid = 1'b1; bus.b_data = 16'h7777;
        bus.out_ready = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
        checks++; if (bus.out_src !== 1'b0) begin failures++; $display("FAIL reset_out_src got=%b want=0", bus.out_src); end
        checks++; if (a_count !== 8'h0 || b_count !== 8'h0) begin failures++; $display("FAIL reset_counts got=%h/%h want=00/00", a_count, b_count); end
        checks++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin failures++; $display("FAIL reset_comb_ready got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready); end
        checks++; if (bus.sel !== 1'b1) begin failures++; $display("FAIL reset_comb_sel got=%b want=1", bus.sel); end
        @(negedge clk);
        bus.b_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_a_only();
        drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1);
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL a_only_ready got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234) begin failures++; $display("FAIL a_only_out got v=%b d=%h want v=1 d=1234", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_src !== 1'b0 || a_count !== 8'd1) begin failures++; $display("FAIL a_only_src_cnt got src=%b cnt=%0d want src=0 cnt=1", bus.out_src, a_count); end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        tick();
    endtask

    task automatic test_tie();
        bit exp_src;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_src = RR ? i[0] : 1'b0;
            drive(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
            checks++; if (bus.a_ready !== !exp_src || bus.b_ready !== exp_src) begin failures++; $display("FAIL tie_ready[%0d] got a=%b b=%b want b=%b", i, bus.a_ready, bus.b_ready, exp_src); end
            tick();
            checks++; if (bus.out_data !== (exp_src ? 16'h5555 : 16'hAAAA) || bus.out_src !== exp_src) begin failures++; $display("FAIL tie_word[%0d] got %h src=%b want src=%b", i, bus.out_data, bus.out_src, exp_src); end
        end
        checks++; if (a_count !== (RR ? 8'd2 : 8'd4) || b_count !== (RR ? 8'd2 : 8'd0)) begin failures++; $display("FAIL tie_counts got a=%0d b=%0d", a_count, b_count); end
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b1);
        tick();
        checks++; if (bus.out_data !== 16'hBEEF || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_fill got v=%b d=%h want v=1 d=beef", bus.out_valid, bus.out_data); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0);
            checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got a=%b b=%b want 0/0", i, bus.a_ready, bus.b_ready); end
            tick();
            checks++; if (bus.out_data !== 16'hBEEF || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=beef", i, bus.out_valid, bus.out_data); end
        end
        drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
        checks++; if (bus.a_ready !== e_ar || bus.b_ready !== e_br || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_release got a=%b b=%b v=%b want a=%b b=%b v=1", bus.a_ready, bus.b_ready, bus.out_valid, e_ar, e_br); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== m_data) begin failures++; $display("FAIL bp_refill got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, m_data); end
    endtask

    task automatic test_drain();
        logic [15:0] held;
        held = m_data;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL drain_ready got a=%b b=%b want 0/0", bus.a_ready, bus.b_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== held || bus.out_src !== m_src) begin failures++; $display("FAIL drain_empty got v=%b d=%h want v=0 d=%h", bus.out_valid, bus.out_data, held); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'hCAFE, 1'b0, 16'h0, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin failures++; $display("FAIL async_rst_out got v=%b d=%h want v=0 d=0000", bus.out_valid, bus.out_data); end
        checks++; if (a_count !== 8'h0 || b_count !== 8'h0) begin failures++; $display("FAIL async_rst_counts got %h/%h want 00/00", a_count, b_count); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin failures++; $display("FAIL async_rst_tie got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
        tick();
        checks++; if (bus.out_data !== 16'hAAAA || bus.out_src !== 1'b0) begin failures++; $display("FAIL async_rst_word got %h src=%b want aaaa src=0", bus.out_data, bus.out_src); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 16'h0, 1'b1, 16'($urandom), 1'b1);
            tick();
            if (i == 254) begin
                checks++; if (b_count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d want=255", b_count); end
            end
            if (i == 255) begin
                checks++; if (b_count !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d want=0", b_count); end
            end
        end
        checks++; if (bus.out_data !== m_data || bus.out_src !== 1'b1) begin failures++; $display("FAIL wrap_last got %h src=%b want %h src=1", bus.out_data, bus.out_src, m_data); end
    endtask

    task automatic test_random();
        logic [16:0] head;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0));
            checks++; if (bus.a_ready !== e_ar || bus.b_ready !== e_br || bus.sel !== e_sel) begin failures++; $display("FAIL rnd_comb[%0d] got a=%b b=%b s=%b want a=%b b=%b s=%b", i, bus.a_ready, bus.b_ready, bus.sel, e_ar, e_br, e_sel); end
            if (bus.out_valid && c_ordy) begin
                head = (exp_q.size() > 0) ? exp_q[0] : 17'h1FFFF;
                checks++; if (exp_q.size() == 0 || {bus.out_src, bus.out_data} !== head) begin failures++; $display("FAIL rnd_order[%0d] got src=%b d=%h want %h", i, bus.out_src, bus.out_data, head); end
            end
            tick();
            checks++; if (bus.out_valid !== m_full || bus.out_data !== m_data || bus.out_src !== m_src) begin failures++; $display("FAIL rnd_reg[%0d] got v=%b d=%h s=%b want v=%b d=%h s=%b", i, bus.out_valid, bus.out_data, bus.out_src, m_full, m_data, m_src); end
            checks++; if (a_count !== m_acnt || b_count !== m_bcnt) begin failures++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, a_count, b_count, m_acnt, m_bcnt); end
        end
        checks++; if (exp_q.size() != int'(bus.out_valid)) begin failures++; $display("FAIL rnd_pending got q=%0d v=%b", exp_q.size(), bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_tie();
        test_backpressure();
        test_drain();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Two-requester arbiter that shares one Mux16 datapath between sources A and B and registers the selected word for a single downstream consumer. It instantiates Mux16 internally, drives its `sel` from the grant decision, and holds the result in an output register with a valid/ready handshake. It sits between two 16-bit producers and one 16-bit bus consumer. It also keeps per-source acceptance counters for debug.

## Interface
- `WIDTH`, 16, data width; fixed at 16 to match Mux16.
- `CNT_W`, 8, width of per-source acceptance counters.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a_data`  in  16  source A word.
- `a_valid`  in  1  source A has a word.
- `a_ready`  out  1  source A word accepted this cycle.
- `b_data`  in  16  source B word.
- `b_valid`  in  1  source B has a word.
- `b_ready`  out  1  source B word accepted this cycle.
- `sel`  out  1  current Mux16 select (0=A, 1=B); combinational.
- `out_data`  out  16  registered selected word.
- `out_src`  out  1  source of `out_data` (0=A, 1=B).
- `out_valid`  out  1  output register full.
- `out_ready`  in  1  consumer accepts `out_data`.
- `a_count`  out  CNT_W  words accepted from A, wrapping.
- `b_count`  out  CNT_W  words accepted from B, wrapping.

## Operation
- Two-state FSM on the output register: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- Grant, combinational:
  - Only one source valid: that source wins.
  - Both valid: winner is the source not recorded in `last_src`.
  - Neither valid: no grant.
- `sel` = grant index. With no grant, `sel` holds 0.
- `a_ready` = `load_en` & grant A. `b_ready` = `load_en` & grant B. Never both high.
- On acceptance:
  - `out_data` <= Mux16(`a_data`, `b_data`, `sel`).
  - `out_src` <= `sel`.
  - `last_src` <= `sel`.
  - The matching counter increments.
  - FSM goes to, or stays, FULL.
- EMPTY, no grant: stay EMPTY.
- FULL, `out_ready`=0: hold all outputs stable; both readies low.
- FULL, `out_ready`=1, no grant: go to EMPTY; `out_data` and `out_src` keep their last values.
- Counters wrap from 2^CNT_W-1 to 0.
- Data is never dropped or duplicated. Each input handshake produces exactly one output handshake, in acceptance order.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `a_count`=0, `b_count`=0.
  - `last_src`=1, so A wins the first tie.
  - FSM=EMPTY.
- Combinational outputs during reset: `a_ready`, `b_ready` and `sel` still follow their equations.
- Latency: a word accepted in cycle N is presented with `out_valid`=1 in cycle N+1.
- Throughput: one word per cycle while `out_ready` is held high.
- Readies depend combinationally on `valid`, `out_ready` and state. Sources must not make `valid` depend on `ready`.
- Reset mid-transfer: the held word is discarded and all state returns to reset values immediately. `out_valid` drops asynchronously.
- Simultaneous drain and refill: both handshakes complete in the same edge.

## Configuration
- `MUX16_ARB_RR_EN` defined: round-robin tie-break as described, using `last_src`.
- Not defined:
  - Fixed priority: A always wins a tie.
  - `last_src` is not implemented.
  - B is served only when A is idle.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then A only: `a_data`=16'h1234, `a_valid`=1, `out_ready`=1. Expect `a_ready`=1 in cycle 0. In cycle 1 expect `out_valid`=1, `out_data`=16'h1234, `out_src`=0, `a_count`=1.
- Tie with `MUX16_ARB_RR_EN`: both valid for 4 cycles, A=16'hAAAA, B=16'h5555, `out_ready`=1. Expect output sequence AAAA, 5555, AAAA, 5555 and `a_count`=`b_count`=2. Without the macro, expect four AAAA words and `b_count`=0.
- Backpressure: fill with 16'hBEEF, then hold `out_ready`=0 for 3 cycles with both sources valid. Expect both readies 0 and `out_data` stable at BEEF. When `out_ready` returns to 1, expect drain and refill in the same cycle.
- Drain to empty: FULL, `out_ready`=1, no valids. Expect `out_valid`=0 on the next cycle and `out_data` unchanged.
- Counter wrap: 256 accepted words from B. Expect `b_count` to go 255 → 0.
- Async reset mid-operation: assert `rst_n`=0 between clock edges while FULL. Expect `out_valid`=0 and `out_data`=0 immediately. After release, a tie goes to A.
